// File: rtl/hdlc_pkg.sv
// Shared HDLC types and constants: FSM state encoding, flag/abort octets, CRC-16 polynomial and step.
package hdlc_pkg;

    typedef enum logic [2:0] {
        TX_IDLE       = 3'd0,
        TX_OPEN_FLAG  = 3'd1,
        TX_DATA       = 3'd2,
        TX_FCS        = 3'd3,
        TX_CLOSE_FLAG = 3'd4,
        TX_ABORT      = 3'd5
    } tx_state_e;

    localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT = 8'hFE;
    localparam logic [15:0] FCS_POLY   = 16'h8005;
    localparam logic [15:0] FCS_INIT   = 16'h0000;

    // One serial CRC step, MSB-out shift register, data bit folded into the feedback.
    function automatic logic [15:0] fcs_step(input logic [15:0] crc, input logic b);
        fcs_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ b) == 1'b1) ? FCS_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/hdlc_tx_fcs.sv
// Serial CRC-16 (x^16+x^15+x^2+1) accumulator for the transmit framer; only used when HDLC_TX_FCS_EN is defined.
module hdlc_tx_fcs
    import hdlc_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_crc <= FCS_INIT;
        end else if (clear) begin
            r_crc <= FCS_INIT;
        end else if (bit_en) begin
            r_crc <= fcs_step(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, zero-stuffed payload, optional FCS (macro HDLC_TX_FCS_EN), abort pattern.
//  state      | meaning
//  IDLE       | line held at 1, waiting for Tx_Start
//  OPEN_FLAG  | sending N_OPEN opening flags
//  DATA       | sending payload bytes LSB first with zero insertion
//  FCS        | sending 16 CRC bits MSB first with zero insertion
//  CLOSE_FLAG | sending closing flag, Tx_Done follows
//  ABORT      | sending 8 abort bits, then IDLE
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = 128,
    parameter int N_OPEN    = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Start,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_DataIn,
    input  logic       Tx_DataValid,
    input  logic       Tx_DataLast,
    output logic       Tx_DataReady,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Underrun,
    output logic [7:0] Tx_FrameSize
);

    tx_state_e   r_state;
    logic        r_tx;
    logic [15:0] r_sreg;
    logic [3:0]  r_bcnt;
    logic [2:0]  r_ones;
    logic [1:0]  r_flag_cnt;
    logic        r_last;
    logic        r_abort_pend;
    logic        r_valid;
    logic        r_done;
    logic        r_aborted;
    logic        r_underrun;
    logic [7:0]  r_size;

    logic w_stuff;
    logic w_req;
    logic w_full;
    logic w_ready;
    logic w_accept;

    // r_bcnt counts bits still to send after the one on Tx; r_ones counts the 1s ending at it.
    assign w_stuff  = ((r_state == TX_DATA) || (r_state == TX_FCS)) && (r_ones == 3'd5);
    assign w_req    = (r_bcnt == 4'd0) && !w_stuff &&
                      (((r_state == TX_OPEN_FLAG) && (r_flag_cnt == 2'd0)) ||
                       ((r_state == TX_DATA) && !r_last));
    assign w_full   = (r_size == 8'(MAX_BYTES));
    assign w_ready  = w_req && !r_abort_pend && !w_full;
    assign w_accept = w_ready && Tx_DataValid;

`ifdef HDLC_TX_FCS_EN
    logic [15:0] w_crc;
    logic [15:0] w_crc_rev;
    logic        w_fcs_clr;
    logic        w_fcs_en;
    logic        w_fcs_bit;

    assign w_fcs_clr = (r_state == TX_IDLE) && Tx_Start;
    assign w_fcs_en  = w_accept ||
                       ((r_state == TX_DATA) && !r_abort_pend && !w_stuff && (r_bcnt != 4'd0));
    assign w_fcs_bit = w_accept ? Tx_DataIn[0] : r_sreg[0];
    // Bit-reversed so the common LSB-first shifter emits the register MSB first.
    assign w_crc_rev = {<<{w_crc}};

    hdlc_tx_fcs u_fcs (
        .Clk    (Clk),
        .Rst    (Rst),
        .clear  (w_fcs_clr),
        .bit_en (w_fcs_en),
        .bit_in (w_fcs_bit),
        .crc    (w_crc)
    );
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= TX_IDLE;
            r_tx         <= 1'b1;
            r_sreg       <= '0;
            r_bcnt       <= '0;
            r_ones       <= '0;
            r_flag_cnt   <= '0;
            r_last       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_underrun   <= 1'b0;
            r_size       <= '0;
        end else begin
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_underrun   <= 1'b0;
            r_abort_pend <= r_abort_pend | (Tx_AbortFrame & r_valid);
            case (r_state)
                TX_IDLE: begin
                    r_tx         <= 1'b1;
                    r_abort_pend <= 1'b0;
                    if (Tx_Start) begin
                        r_state    <= TX_OPEN_FLAG;
                        r_tx       <= HDLC_FLAG[0];
                        r_sreg     <= {9'h000, HDLC_FLAG[7:1]};
                        r_bcnt     <= 4'd7;
                        r_flag_cnt <= 2'(N_OPEN - 1);
                        r_ones     <= '0;
                        r_last     <= 1'b0;
                        r_size     <= '0;
                        r_valid    <= 1'b1;
                    end
                end
                TX_ABORT: begin
                    r_abort_pend <= 1'b0;
                    if (r_bcnt != 4'd0) begin
                        r_tx   <= r_sreg[0];
                        r_sreg <= r_sreg >> 1;
                        r_bcnt <= r_bcnt - 4'd1;
                    end else begin
                        r_state <= TX_IDLE;
                        r_tx    <= 1'b1;
                    end
                end
                default: begin
                    if (r_abort_pend || (w_req && !w_accept)) begin
                        r_state      <= TX_ABORT;
                        r_tx         <= HDLC_ABORT[0];
                        r_sreg       <= {9'h000, HDLC_ABORT[7:1]};
                        r_bcnt       <= 4'd7;
                        r_ones       <= '0;
                        r_valid      <= 1'b0;
                        r_aborted    <= 1'b1;
                        r_abort_pend <= 1'b0;
                        r_underrun   <= !r_abort_pend && !Tx_DataValid;
                    end else if (w_stuff) begin
                        r_tx   <= 1'b0;
                        r_ones <= '0;
                    end else if (r_bcnt != 4'd0) begin
                        r_tx   <= r_sreg[0];
                        r_sreg <= r_sreg >> 1;
                        r_bcnt <= r_bcnt - 4'd1;
                        r_ones <= (((r_state == TX_DATA) || (r_state == TX_FCS)) && r_sreg[0]) ?
                                  r_ones + 3'd1 : 3'd0;
                    end else if (w_accept) begin
                        r_state <= TX_DATA;
                        r_tx    <= Tx_DataIn[0];
                        r_sreg  <= {9'h000, Tx_DataIn[7:1]};
                        r_bcnt  <= 4'd7;
                        r_ones  <= Tx_DataIn[0] ? r_ones + 3'd1 : 3'd0;
                        r_last  <= Tx_DataLast;
                        r_size  <= r_size + 8'd1;
                    end else if ((r_state == TX_OPEN_FLAG) && (r_flag_cnt != 2'd0)) begin
                        r_tx       <= HDLC_FLAG[0];
                        r_sreg     <= {9'h000, HDLC_FLAG[7:1]};
                        r_bcnt     <= 4'd7;
                        r_flag_cnt <= r_flag_cnt - 2'd1;
`ifdef HDLC_TX_FCS_EN
                    end else if (r_state == TX_DATA) begin
                        r_state <= TX_FCS;
                        r_tx    <= w_crc[15];
                        r_sreg  <= w_crc_rev >> 1;
                        r_bcnt  <= 4'd15;
                        r_ones  <= w_crc[15] ? r_ones + 3'd1 : 3'd0;
`endif
                    end else if (r_state == TX_CLOSE_FLAG) begin
                        r_state      <= TX_IDLE;
                        r_tx         <= 1'b1;
                        r_valid      <= 1'b0;
                        r_done       <= 1'b1;
                        r_abort_pend <= 1'b0;
                    end else begin
                        r_state <= TX_CLOSE_FLAG;
                        r_tx    <= HDLC_FLAG[0];
                        r_sreg  <= {9'h000, HDLC_FLAG[7:1]};
                        r_bcnt  <= 4'd7;
                        r_ones  <= '0;
                    end
                end
            endcase
        end
    end

    assign Tx              = r_tx;
    assign Tx_DataReady    = w_ready;
    assign Tx_ValidFrame   = r_valid;
    assign Tx_Done         = r_done;
    assign Tx_AbortedTrans = r_aborted;
    assign Tx_Underrun     = r_underrun;
    assign Tx_FrameSize    = r_size;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: bit-exact frames, stuffing, abort, underrun, size limit, reset.
module tb_hdlc_tx_framer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Tx_Start = 1'b0;
    logic       Tx_AbortFrame = 1'b0;
    logic [7:0] Tx_DataIn = 8'h00;
    logic       Tx_DataValid = 1'b0;
    logic       Tx_DataLast = 1'b0;
    logic       Tx_DataReady;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;
    logic       Tx_Underrun;
    logic [7:0] Tx_FrameSize;

    always #5 Clk = ~Clk;

    hdlc_tx_framer #(.MAX_BYTES(128), .N_OPEN(1)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Tx_Start        (Tx_Start),
        .Tx_AbortFrame   (Tx_AbortFrame),
        .Tx_DataIn       (Tx_DataIn),
        .Tx_DataValid    (Tx_DataValid),
        .Tx_DataLast     (Tx_DataLast),
        .Tx_DataReady    (Tx_DataReady),
        .Tx              (Tx),
        .Tx_ValidFrame   (Tx_ValidFrame),
        .Tx_Done         (Tx_Done),
        .Tx_AbortedTrans (Tx_AbortedTrans),
        .Tx_Underrun     (Tx_Underrun),
        .Tx_FrameSize    (Tx_FrameSize)
    );

    int total = 0;
    int bad   = 0;

    logic [127:0] cap;
    logic [127:0] rdy;
    int n_xfer, n_done, n_abt, n_und, n_vf, i_done, i_abt, i_und;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        cap = '0; rdy = '0;
        n_xfer = 0; n_done = 0; n_abt = 0; n_und = 0; n_vf = 0;
        i_done = -1; i_abt = -1; i_und = -1;
    endtask

    // Sample one cycle per negedge; index 0 is the first cycle after the start edge.
    task automatic grab(input int n, input int abort_at, input int start_at);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (i < 128) begin
                cap[i] = Tx;
                rdy[i] = Tx_DataReady;
            end
            if (Tx_DataReady && Tx_DataValid) n_xfer++;
            if (Tx_Done) begin n_done++; if (i_done < 0) i_done = i; end
            if (Tx_AbortedTrans) begin n_abt++; if (i_abt < 0) i_abt = i; end
            if (Tx_Underrun) begin n_und++; if (i_und < 0) i_und = i; end
            if (Tx_ValidFrame) n_vf++;
            Tx_Start      = (i == start_at);
            Tx_AbortFrame = (i == abort_at);
        end
    endtask

`ifdef HDLC_TX_FCS_EN
    logic [7:0]  fb [3];
    logic [39:0] dbits;
    logic [15:0] ref_crc, got_fcs;

    task automatic run_fcs_frame(input int stop_after_last);
        int k = 0;
        int post = 0;
        logic pend = 1'b0;
        Tx_DataValid = 1'b1;
        Tx_DataIn = fb[0];
        Tx_DataLast = 1'b0;
        Tx_Start = 1'b1;
        clr_stats();
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            @(negedge Clk);
            Tx_Start = 1'b0;
            if (pend) k++;
            if (k < 3) begin
                Tx_DataIn = fb[k];
                Tx_DataLast = (k == 2);
            end
            if (i < 128) cap[i] = Tx;
            pend = Tx_DataReady && Tx_DataValid;
            if (Tx_Done) begin n_done++; i_done = i; end
            if (k == 3) post++;
            if (stop_after_last > 0 && post == stop_after_last) break;
        end
    endtask
`endif

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_tx", Tx, 1);
        chk("rst_ready", Tx_DataReady, 0);
        chk("rst_vf", Tx_ValidFrame, 0);
        chk("rst_done", Tx_Done, 0);
        chk("rst_abt", Tx_AbortedTrans, 0);
        chk("rst_und", Tx_Underrun, 0);
        chk("rst_size", Tx_FrameSize, 0);
        Rst = 1'b0;
        @(negedge Clk);

        // Abort while idle has no effect.
        Tx_AbortFrame = 1'b1;
        clr_stats();
        grab(4, -1, -1);
        chk("idle_abort_tx", cap[3:0], 4'hF);
        chk("idle_abort_pulse", n_abt, 0);
        chk("idle_abort_vf", n_vf, 0);

`ifndef HDLC_TX_FCS_EN
        // Single 0x00 byte; a second Tx_Start mid-frame must be ignored.
        Tx_DataValid = 1'b1; Tx_DataIn = 8'h00; Tx_DataLast = 1'b1;
        Tx_Start = 1'b1;
        clr_stats();
        grab(25, -1, 12);
        chk("f00_bits", cap[24:0], {1'b1, 24'h7E007E});
        chk("f00_done_idx", i_done, 24);
        chk("f00_xfer", n_xfer, 1);
        chk("f00_vf_cycles", n_vf, 24);
        chk("f00_size", Tx_FrameSize, 1);

        // 0xFF byte: zero inserted after the fifth 1, no request during the stuffed bit.
        Tx_DataIn = 8'hFF; Tx_DataLast = 1'b1;
        Tx_Start = 1'b1;
        clr_stats();
        grab(26, -1, -1);
        chk("fff_bits", cap[25:0], {1'b1, 8'h7E, 9'h1DF, 8'h7E});
        chk("fff_ready_map", rdy[25:0], 26'h80);
        chk("fff_done_idx", i_done, 25);
        chk("fff_size", Tx_FrameSize, 1);
`else
        fb[0] = 8'($urandom); fb[1] = 8'($urandom); fb[2] = 8'($urandom);
        run_fcs_frame(0);
        chk("fcs_done", n_done, 1);
        begin
            int ones = 0;
            int m = 0;
            dbits = '0;
            for (int j = 8; j <= i_done - 9; j++) begin
                if (ones == 5) begin
                    ones = 0;
                end else begin
                    if (m < 40) dbits[m] = cap[j];
                    m++;
                    ones = cap[j] ? ones + 1 : 0;
                end
            end
            chk("fcs_destuffed_len", m, 40);
            chk("fcs_payload", dbits[23:0], {fb[2], fb[1], fb[0]});
            ref_crc = 16'h0000;
            for (int b = 0; b < 24; b++) begin
                logic fbk;
                fbk = ref_crc[15] ^ dbits[b];
                ref_crc = {ref_crc[14:0], 1'b0} ^ (fbk ? 16'h8005 : 16'h0000);
            end
            for (int j = 0; j < 16; j++) got_fcs[15 - j] = dbits[24 + j];
            chk("fcs_value", got_fcs, ref_crc);
            chk("fcs_close_flag", cap[i_done - 1 -: 8], 8'h7E);
        end
        run_fcs_frame(12);
        Rst = 1'b1;
        #1;
        chk("fcs_rst_tx", Tx, 1);
        chk("fcs_rst_vf", Tx_ValidFrame, 0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
`endif

        // Abort request mid-byte: current and next bit complete, then 01111111.
        Tx_DataValid = 1'b1; Tx_DataIn = 8'h55; Tx_DataLast = 1'b0;
        Tx_Start = 1'b1;
        clr_stats();
        grab(23, 11, -1);
        chk("abt_bits", cap[21:0], {1'b1, 8'hFE, 5'h15, 8'h7E});
        chk("abt_pulse_idx", i_abt, 13);
        chk("abt_pulse_cnt", n_abt, 1);
        chk("abt_vf_cycles", n_vf, 13);
        chk("abt_no_done", n_done, 0);
        chk("abt_size", Tx_FrameSize, 1);

        // No data at the first request: underrun and abort right after the opening flag.
        Tx_DataValid = 1'b0;
        Tx_Start = 1'b1;
        clr_stats();
        grab(18, -1, -1);
        chk("und_bits", cap[17:0], {2'b11, 8'hFE, 8'h7E});
        chk("und_idx", i_und, 8);
        chk("und_abt_idx", i_abt, 8);
        chk("und_cnt", n_und, 1);
        chk("und_size", Tx_FrameSize, 0);
        chk("und_no_done", n_done, 0);

        // Endless stream: 128 bytes accepted, the 129th refused and the frame aborted.
        Tx_DataValid = 1'b1; Tx_DataIn = 8'hA5; Tx_DataLast = 1'b0;
        Tx_Start = 1'b1;
        clr_stats();
        for (int cyc = 0; cyc < 2000 && n_abt == 0; cyc++) grab(1, -1, -1);
        chk("max_abort_seen", n_abt, 1);
        chk("max_xfer", n_xfer, 128);
        chk("max_size", Tx_FrameSize, 128);
        chk("max_no_underrun", n_und, 0);
        grab(10, -1, -1);
        chk("max_idle_after", Tx, 1);

        // Start and abort together in idle: start wins. Then reset mid-frame: no abort pattern.
        Tx_DataIn = 8'h00; Tx_DataLast = 1'b0;
        Tx_Start = 1'b1; Tx_AbortFrame = 1'b1;
        clr_stats();
        grab(12, -1, -1);
        chk("sa_bits", cap[11:0], 12'h07E);
        chk("sa_no_abort", n_abt, 0);
        chk("sa_vf_cycles", n_vf, 12);
        Rst = 1'b1;
        #1;
        chk("rmid_tx", Tx, 1);
        chk("rmid_vf", Tx_ValidFrame, 0);
        chk("rmid_size", Tx_FrameSize, 0);
        @(negedge Clk);
        Rst = 1'b0;
        clr_stats();
        grab(3, -1, -1);
        chk("rmid_idle_bits", cap[2:0], 3'b111);
        chk("rmid_no_abort", n_abt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
